// File: rtl/sdram_refresh_executor.sv
// Responder side of the SDRAM refresh handshake: acquires the command bus, issues PRECHARGE ALL / AUTO REFRESH.
// Optional macro SDRAM_REFRESH_BURST_EN allows back-to-back refreshes within one bus grant.
module sdram_refresh_executor #(
    parameter int T_RP      = 3,
    parameter int T_RFC     = 9,
    parameter int BW_TIMER  = 4,
    parameter int BURST_MAX = 4,
    parameter int BW_BURST  = 3
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       refresh_i,
    input  logic       bank_open_i,
    output logic       bus_req_o,
    input  logic       bus_gnt_i,
    output logic       execute_o,
    output logic [3:0] cmd_o,
    output logic       a10_o,
    output logic       busy_o
);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    // Wait states count down to zero, so the load value is two short of the spacing.
    localparam logic [BW_TIMER-1:0] RP_LOAD  = BW_TIMER'(T_RP - 2);
    localparam logic [BW_TIMER-1:0] RFC_LOAD = BW_TIMER'(T_RFC - 2);

    if (T_RP < 2 || T_RFC < 2 || (T_RP - 2) >= (2 ** BW_TIMER) || (T_RFC - 2) >= (2 ** BW_TIMER)
        || BURST_MAX < 1 || BURST_MAX >= (2 ** BW_BURST)) begin : g_param_check
        $error("sdram_refresh_executor: illegal timing or burst parameters");
    end

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        PRE,
        WAIT_RP,
        REF,
        WAIT_RFC
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [BW_TIMER-1:0] timer;
    logic                burst_more;

    logic                req_nxt;
    logic                exec_nxt;
    logic [3:0]          cmd_nxt;
    logic                a10_nxt;
    logic                busy_nxt;

`ifdef SDRAM_REFRESH_BURST_EN
    localparam logic [BW_BURST-1:0] BURST_LIM = BW_BURST'(BURST_MAX);

    logic [BW_BURST-1:0] burst;

    // Counts REFs issued under the current grant; saturates at the burst limit.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            burst <= '0;
        end else if (state == REQ && bus_gnt_i) begin
            burst <= '0;
        end else if (state == REF && burst < BURST_LIM) begin
            burst <= burst + 1'b1;
        end
    end

    assign burst_more = refresh_i && (burst < BURST_LIM);
`else
    assign burst_more = 1'b0;
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            timer <= '0;
        end else begin
            case (state)
                PRE:               timer <= RP_LOAD;
                REF:               timer <= RFC_LOAD;
                WAIT_RP, WAIT_RFC: if (timer != '0) timer <= timer - 1'b1;
                default:           timer <= timer;
            endcase
        end
    end

    // State register; outputs are registered from the next-state decode so they align with state.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            bus_req_o <= 1'b0;
            execute_o <= 1'b0;
            cmd_o     <= CMD_NOP;
            a10_o     <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state     <= state_nxt;
            bus_req_o <= req_nxt;
            execute_o <= exec_nxt;
            cmd_o     <= cmd_nxt;
            a10_o     <= a10_nxt;
            busy_o    <= busy_nxt;
        end
    end

    // Grant is only looked at in REQ; afterwards the arbiter holds it until we drop the request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (refresh_i) state_nxt = REQ;
            REQ:      if (bus_gnt_i) state_nxt = bank_open_i ? PRE : REF;
            PRE:      state_nxt = WAIT_RP;
            WAIT_RP:  if (timer == '0) state_nxt = REF;
            REF:      state_nxt = WAIT_RFC;
            WAIT_RFC: if (timer == '0) state_nxt = burst_more ? REF : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_nxt  = (state_nxt != IDLE);
        busy_nxt = (state_nxt != IDLE);
        exec_nxt = 1'b0;
        a10_nxt  = 1'b0;
        cmd_nxt  = CMD_NOP;
        case (state_nxt)
            PRE: begin
                cmd_nxt = CMD_PRE;
                a10_nxt = 1'b1;
            end
            REF: begin
                cmd_nxt  = CMD_REF;
                exec_nxt = 1'b1;
            end
            default: begin
                cmd_nxt = CMD_NOP;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_refresh_executor.sv
// Randomized bench for sdram_refresh_executor against a command-schedule reference model.
module tb_sdram_refresh_executor;

    localparam int T_RP      = 3;
    localparam int T_RFC     = 9;
    localparam int BW_TIMER  = 4;
    localparam int BURST_MAX = 4;
    localparam int BW_BURST  = 3;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

`ifdef SDRAM_REFRESH_BURST_EN
    localparam int MIN_REF_GAP = T_RFC;
`else
    localparam int MIN_REF_GAP = T_RFC + 2;
`endif

    logic       clock_i     = 1'b0;
    logic       reset_i     = 1'b1;
    logic       refresh_i   = 1'b0;
    logic       bank_open_i = 1'b0;
    logic       bus_gnt_i   = 1'b0;
    logic       bus_req_o;
    logic       execute_o;
    logic [3:0] cmd_o;
    logic       a10_o;
    logic       busy_o;

    sdram_refresh_executor #(
        .T_RP      (T_RP),
        .T_RFC     (T_RFC),
        .BW_TIMER  (BW_TIMER),
        .BURST_MAX (BURST_MAX),
        .BW_BURST  (BW_BURST)
    ) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .refresh_i   (refresh_i),
        .bank_open_i (bank_open_i),
        .bus_req_o   (bus_req_o),
        .bus_gnt_i   (bus_gnt_i),
        .execute_o   (execute_o),
        .cmd_o       (cmd_o),
        .a10_o       (a10_o),
        .busy_o      (busy_o)
    );

    always #5 clock_i = ~clock_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: a sequence is a schedule of absolute cycle numbers for PRE, REF and release.
    int   cyc      = 0;
    bit   m_active = 1'b0;
    bit   m_wait   = 1'b0;
    int   m_pre    = -1;
    int   m_ref    = -1;
    int   m_end    = -1;
    int   m_burst  = 0;
    logic [3:0] e_cmd;
    logic e_req, e_exec, e_a10, e_busy;

    int gnt_delay  = 0;
    int prev_ref   = -1;
    int last_pre   = -1;
    int exec_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_expected();
        e_req  = m_active;
        e_busy = m_active;
        e_cmd  = CMD_NOP;
        e_exec = 1'b0;
        e_a10  = 1'b0;
        if (m_active && cyc == m_pre) begin
            e_cmd = CMD_PRE;
            e_a10 = 1'b1;
        end
        if (m_active && cyc == m_ref) begin
            e_cmd  = CMD_REF;
            e_exec = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_wait   = 1'b0;
        m_pre    = -1;
        m_ref    = -1;
        m_end    = -1;
        m_burst  = 0;
        prev_ref = -1;
        last_pre = -1;
        set_expected();
    endtask

    // Called just after a rising edge: inputs still hold the values the DUT sampled.
    task automatic model_step();
        cyc++;
        if (!m_active) begin
            if (refresh_i) begin
                m_active = 1'b1;
                m_wait   = 1'b1;
            end
        end else if (m_wait) begin
            if (bus_gnt_i) begin
                m_wait  = 1'b0;
                m_burst = 1;
                if (bank_open_i) begin
                    m_pre = cyc;
                    m_ref = cyc + T_RP;
                end else begin
                    m_pre = -1;
                    m_ref = cyc;
                end
                m_end = m_ref + T_RFC;
            end
        end else if (cyc == m_end) begin
`ifdef SDRAM_REFRESH_BURST_EN
            if (refresh_i && m_burst < BURST_MAX) begin
                m_ref = cyc;
                m_end = cyc + T_RFC;
                m_pre = -1;
                m_burst++;
            end else begin
                m_active = 1'b0;
            end
`else
            m_active = 1'b0;
`endif
        end
        set_expected();
    endtask

    task automatic check_outputs();
        check("bus_req", bus_req_o, e_req);
        check("busy", busy_o, e_busy);
        check("cmd", cmd_o, e_cmd);
        check("execute", execute_o, e_exec);
        check("a10", a10_o, e_a10);
        if (execute_o) exec_count++;
        if (cmd_o == CMD_REF) begin
            if (last_pre >= 0) begin
                check("pre_to_ref", cyc - last_pre, T_RP);
                last_pre = -1;
            end
            if (prev_ref >= 0) check("ref_gap_ok", (cyc - prev_ref) >= MIN_REF_GAP, 1);
            prev_ref = cyc;
        end
        if (a10_o) last_pre = cyc;
    endtask

    // rmode: 0 held high, 1 random, 2 single pulse, 3 low. bmode: 0 closed, 1 open, 2 random.
    task automatic drive_inputs(input int rmode, input int bmode, input int dmin, input int dmax, input bit first);
        case (rmode)
            0:       refresh_i = 1'b1;
            1:       refresh_i = 1'($urandom_range(0, 1));
            2:       refresh_i = first;
            default: refresh_i = 1'b0;
        endcase
        case (bmode)
            0:       bank_open_i = 1'b0;
            1:       bank_open_i = 1'b1;
            default: bank_open_i = 1'($urandom_range(0, 1));
        endcase
        if (!m_active) begin
            bus_gnt_i = 1'b0;
            gnt_delay = $urandom_range(dmin, dmax);
        end else if (m_wait) begin
            if (gnt_delay == 0) begin
                bus_gnt_i = 1'b1;
            end else begin
                gnt_delay--;
                bus_gnt_i = 1'b0;
            end
        end else begin
            bus_gnt_i = 1'b1;
        end
    endtask

    task automatic run(input int n, input int rmode, input int bmode, input int dmin, input int dmax);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_i);
            model_step();
            @(negedge clock_i);
            check_outputs();
            drive_inputs(rmode, bmode, dmin, dmax, i == 0);
        end
    endtask

    initial begin : main
        int n;
        model_reset();
        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        check_outputs();
        reset_i = 1'b0;

        run(40, 0, 0, 2, 2);
        run(30, 3, 0, 0, 0);
        run(40, 0, 1, 0, 3);
        run(30, 3, 0, 0, 0);

        exec_count = 0;
        run(40, 2, 2, 5, 5);
        check("pulse_exec_count", exec_count, 1);

        run(400, 1, 2, 0, 4);
        run(200, 0, 2, 0, 6);

        n = 0;
        while (!(m_active && !m_wait && cyc > m_ref && cyc < m_end) && n < 100) begin
            @(posedge clock_i);
            model_step();
            @(negedge clock_i);
            check_outputs();
            drive_inputs(0, 2, 0, 3, 1'b0);
            n++;
        end
        check("wait_rfc_reached", n < 100, 1);
        refresh_i = 1'b1;
        reset_i   = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clock_i);
        @(negedge clock_i);
        check_outputs();
        reset_i = 1'b0;

        run(150, 1, 2, 0, 3);
        run(30, 3, 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
